// File: rtl/p2a_cpl_mapper.sv
// p2a_cpl_mapper
//   Maps PCIe completions (Cpl/CplD) from the Rx router onto AXI4 slave B/R
//   responses. Keeps its own outstanding-request tag table, filled by the
//   A2P request path, tracks split read completions, generates RLAST and
//   frees tags. Unexpected completions are dropped with a unexp_cpl pulse.
// Ports:
//   clk, arst (async, active-low)
//   alloc_*   : request path records a non-posted request (valid/ready)
//   cpl_*     : completion header + payload from the Rx router (valid/ready)
//   b_*       : AXI B response (valid/ready)
//   r_*       : AXI R response (valid/ready)
//   unexp_cpl : one-cycle pulse when a completion is dropped
//   outstanding : number of valid table entries
module p2a_cpl_mapper #(
  parameter int NUM_TAGS = 32,
  parameter int TAG_W    = $clog2(NUM_TAGS),
  parameter int ID_W     = 8,
  parameter int DATA_W   = 1024
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  input  logic [TAG_W-1:0]  alloc_tag,
  input  logic [ID_W-1:0]   alloc_id,
  input  logic              alloc_is_read,
  input  logic [10:0]       alloc_len_dw,
  input  logic              cpl_valid,
  output logic              cpl_ready,
  input  logic [TAG_W-1:0]  cpl_tag,
  input  logic [2:0]        cpl_status,
  input  logic              cpl_has_data,
  input  logic [9:0]        cpl_length,
  input  logic [DATA_W-1:0] cpl_data,
  output logic              b_valid,
  input  logic              b_ready,
  output logic [ID_W-1:0]   b_id,
  output logic [1:0]        b_resp,
  output logic              r_valid,
  input  logic              r_ready,
  output logic [ID_W-1:0]   r_id,
  output logic [DATA_W-1:0] r_data,
  output logic [1:0]        r_resp,
  output logic              r_last,
  output logic              unexp_cpl,
  output logic [TAG_W:0]    outstanding
);

  localparam logic [10:0] MAX_DW = 11'(DATA_W / 32);

  typedef enum logic [1:0] {IDLE, EVAL, B_OUT, R_OUT} state_t;

  state_t              r_state;
  logic [NUM_TAGS-1:0] r_tbl_vld;
  logic [NUM_TAGS-1:0] r_tbl_rd;
  logic [ID_W-1:0]     r_tbl_id  [NUM_TAGS];
  logic [10:0]         r_tbl_rem [NUM_TAGS];

  logic [TAG_W-1:0]    r_c_tag;
  logic [2:0]          r_c_status;
  logic                r_c_hasd;
  logic [9:0]          r_c_len;
  logic [DATA_W-1:0]   r_c_data;

  logic                r_b_valid;
  logic [ID_W-1:0]     r_b_id;
  logic [1:0]          r_b_resp;
  logic                r_r_valid;
  logic [ID_W-1:0]     r_r_id;
  logic [DATA_W-1:0]   r_r_data;
  logic [1:0]          r_r_resp;
  logic                r_r_last;
  logic                r_unexp;
  logic [TAG_W:0]      r_outstanding;

  logic                w_alloc_fire;
  logic                w_free;
  logic [10:0]         w_eff;
  logic                w_ent_vld;
  logic                w_ent_rd;
  logic [ID_W-1:0]     w_ent_id;
  logic [10:0]         w_ent_rem;
  logic [1:0]          w_map;
  logic                w_good;

  // A valid tag refuses allocation, so a same-cycle free of that tag always
  // wins and the request path retries on the following cycle.
  assign alloc_ready  = ~r_tbl_vld[alloc_tag];
  assign w_alloc_fire = alloc_valid & alloc_ready;
  assign cpl_ready    = (r_state == IDLE);

  assign w_free = ((r_state == B_OUT) & b_ready) |
                  ((r_state == R_OUT) & r_ready & r_r_last);

  assign w_eff     = (r_c_len == 10'd0) ? 11'd1024 : {1'b0, r_c_len};
  assign w_ent_vld = r_tbl_vld[r_c_tag];
  assign w_ent_rd  = r_tbl_rd[r_c_tag];
  assign w_ent_id  = r_tbl_id[r_c_tag];
  assign w_ent_rem = r_tbl_rem[r_c_tag];

  always_comb begin
    w_map = 2'b10;
    case (r_c_status)
      3'b000:  w_map = 2'b00;
      3'b001:  w_map = 2'b11;
      default: w_map = 2'b10;
    endcase
  end

  assign w_good = r_c_hasd & (r_c_status == 3'b000) &
                  (w_eff <= w_ent_rem) & (w_eff <= MAX_DW);

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      r_state       <= IDLE;
      r_tbl_vld     <= '0;
      r_tbl_rd      <= '0;
      for (int unsigned i = 0; i < NUM_TAGS; i++) begin
        r_tbl_id[i]  <= '0;
        r_tbl_rem[i] <= '0;
      end
      r_c_tag       <= '0;
      r_c_status    <= '0;
      r_c_hasd      <= 1'b0;
      r_c_len       <= '0;
      r_c_data      <= '0;
      r_b_valid     <= 1'b0;
      r_b_id        <= '0;
      r_b_resp      <= '0;
      r_r_valid     <= 1'b0;
      r_r_id        <= '0;
      r_r_data      <= '0;
      r_r_resp      <= '0;
      r_r_last      <= 1'b0;
      r_unexp       <= 1'b0;
      r_outstanding <= '0;
    end else begin
      r_unexp <= 1'b0;

      if (w_alloc_fire) begin
        r_tbl_vld[alloc_tag] <= 1'b1;
        r_tbl_rd[alloc_tag]  <= alloc_is_read;
        r_tbl_id[alloc_tag]  <= alloc_id;
        r_tbl_rem[alloc_tag] <= alloc_len_dw;
      end

      case ({w_alloc_fire, w_free})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase

      case (r_state)
        IDLE: begin
          if (cpl_valid) begin
            r_c_tag    <= cpl_tag;
            r_c_status <= cpl_status;
            r_c_hasd   <= cpl_has_data;
            r_c_len    <= cpl_length;
            r_c_data   <= cpl_data;
            r_state    <= EVAL;
          end
        end
        EVAL: begin
          if (!w_ent_vld) begin
            r_unexp <= 1'b1;
            r_state <= IDLE;
          end else if (!w_ent_rd) begin
            if (!r_c_hasd) begin
              r_b_valid <= 1'b1;
              r_b_id    <= w_ent_id;
              r_b_resp  <= w_map;
              r_state   <= B_OUT;
            end else begin
              // Data on a write completion: drop it but keep the entry so
              // the genuine completion can still retire the request.
              r_unexp <= 1'b1;
              r_state <= IDLE;
            end
          end else begin
            r_r_valid <= 1'b1;
            r_r_id    <= w_ent_id;
            r_state   <= R_OUT;
            if (w_good) begin
              r_r_data             <= r_c_data;
              r_r_resp             <= 2'b00;
              r_r_last             <= (w_ent_rem == w_eff);
              r_tbl_rem[r_c_tag]   <= w_ent_rem - w_eff;
            end else begin
              // Error or malformed: terminate the burst with one beat.
              r_r_data <= '0;
              r_r_resp <= (r_c_status == 3'b000) ? 2'b10 : w_map;
              r_r_last <= 1'b1;
            end
          end
        end
        B_OUT: begin
          if (b_ready) begin
            r_b_valid          <= 1'b0;
            r_tbl_vld[r_c_tag] <= 1'b0;
            r_state            <= IDLE;
          end
        end
        R_OUT: begin
          if (r_ready) begin
            r_r_valid <= 1'b0;
            r_r_last  <= 1'b0;
            if (r_r_last) r_tbl_vld[r_c_tag] <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign b_valid     = r_b_valid;
  assign b_id        = r_b_id;
  assign b_resp      = r_b_resp;
  assign r_valid     = r_r_valid;
  assign r_id        = r_r_id;
  assign r_data      = r_r_data;
  assign r_resp      = r_r_resp;
  assign r_last      = r_r_last;
  assign unexp_cpl   = r_unexp;
  assign outstanding = r_outstanding;

endmodule
